mul_sequencer: RTL and testbench

- Multi-cycle iterative multiply engine and stall controller for the MIPS datapath.
- It serves the R-type mul instruction (opcode 6'b000000, funct 6'b011000).
- It sits beside the EX stage. When the instruction decoder flags a mul, it latches the operands and holds the pipeline with stall while a shift-add FSM runs. It then presents the low 32 bits of the product with a one-cycle register-write strobe.
- Early termination: latency tracks the highest set bit of the multiplier operand, so small multipliers finish quickly.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mul_sequencer.sv | 125 ++++++++++++
 tb/tb_mul_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants: mul instruction encoding, register address width
// and the multiply sequencer state encoding.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNCT_MUL  = 6'b011000;

    localparam int MIPS_REG_ADDR_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_mul(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) && (funct == FUNCT_MUL);
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier that stalls the pipeline while it runs and
// terminates early once the remaining multiplier bits are all zero.
module mul_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = mips_pkg::MIPS_REG_ADDR_W
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      rs_val,
    input  logic [WIDTH-1:0]      rt_val,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  stall,
    output logic                  done,
    output logic                  reg_write,
    output logic [WIDTH-1:0]      result,
    output logic [REG_ADDR_W-1:0] result_reg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]            r_state;
    logic [WIDTH-1:0]      r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [WIDTH-1:0]      r_acc;
    logic [CNT_W-1:0]      r_count;
    logic [REG_ADDR_W-1:0] r_dest;
    logic                  r_done;
    logic [WIDTH-1:0]      r_result;
    logic [REG_ADDR_W-1:0] r_result_reg;

    logic                  w_accept;
    logic                  w_rt_zero;
    logic [WIDTH-1:0]      w_addend;
    logic [WIDTH-1:0]      w_acc_next;
    logic                  w_run_last;

    assign w_accept   = start & ~flush;
    assign w_rt_zero  = (rt_val == {WIDTH{1'b0}});
    assign w_addend   = r_mplier[0] ? r_mcand : {WIDTH{1'b0}};
    assign w_acc_next = r_acc + w_addend;
    // Last iteration when no set bits remain above bit 0 of the multiplier.
    assign w_run_last = (r_mplier[WIDTH-1:1] == {(WIDTH-1){1'b0}}) || (r_count == CNT_LAST);

    // Stall request: pending accept in IDLE/DONE, or the engine is iterating.
    always_comb begin
        stall = 1'b0;
        if (r_state == ST_RUN) begin
            stall = 1'b1;
        end else if (w_accept && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Sequencer FSM and shift-add datapath.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_mcand      <= {WIDTH{1'b0}};
            r_mplier     <= {WIDTH{1'b0}};
            r_acc        <= {WIDTH{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_dest       <= {REG_ADDR_W{1'b0}};
            r_done       <= 1'b0;
            r_result     <= {WIDTH{1'b0}};
            r_result_reg <= {REG_ADDR_W{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_mcand  <= rs_val;
                        r_mplier <= rt_val;
                        r_acc    <= {WIDTH{1'b0}};
                        r_count  <= {CNT_W{1'b0}};
                        r_dest   <= dest_reg;
                        if (w_rt_zero) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_result     <= {WIDTH{1'b0}};
                            r_result_reg <= dest_reg;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (w_run_last) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_result     <= w_acc_next;
                            r_result_reg <= r_dest;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done       = r_done;
    assign reg_write  = r_done;
    assign result     = r_result;
    assign result_reg = r_result_reg;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer: latency, result, stall,
// flush, back-to-back and reset behaviour against hand-computed values.
module tb_mul_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        start;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  dest_reg;
    logic        stall;
    logic        done;
    logic        reg_write;
    logic [31:0] result;
    logic [4:0]  result_reg;

    int n_checks = 0;
    int n_errors = 0;

    mul_sequencer #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .start      (start),
        .flush      (flush),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .dest_reg   (dest_reg),
        .stall      (stall),
        .done       (done),
        .reg_write  (reg_write),
        .result     (result),
        .result_reg (result_reg)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic launch(input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
        start    = 1'b1;
        rs_val   = rs;
        rt_val   = rt;
        dest_reg = rd;
        #1;
        check_eq("launch_stall", {31'd0, stall}, 32'd1);
    endtask

    // Runs from the start cycle until done; exp_ticks counts edges including the sampling edge.
    task automatic wait_done(input string tag, input int exp_ticks, input bit hold,
                             input logic [31:0] exp_res, input logic [4:0] exp_rd);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (!(hold && (cyc < exp_ticks - 1))) start = 1'b0;
            #1;
            if (done !== 1'b1) check_eq({tag, "_stall"}, {31'd0, stall}, 32'd1);
        end while ((done !== 1'b1) && (cyc < 60));
        check_eq({tag, "_latency"}, cyc, exp_ticks);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_regwrite"}, {31'd0, reg_write}, 32'd1);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_resreg"}, {27'd0, result_reg}, {27'd0, exp_rd});
    endtask

    // Finish a done cycle with no new start and verify the single-cycle pulse.
    task automatic finish_idle(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd);
        check_eq({tag, "_donecyc_stall"}, {31'd0, stall}, 32'd0);
        tick();
        #1;
        check_eq({tag, "_after_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_after_regwrite"}, {31'd0, reg_write}, 32'd0);
        check_eq({tag, "_hold_result"}, result, exp_res);
        check_eq({tag, "_hold_resreg"}, {27'd0, result_reg}, {27'd0, exp_rd});
    endtask

    initial begin
        bit seen_done;
        RESET    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        dest_reg = 5'd0;
        #1;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        tick();
        tick();
        RESET = 1'b0;
        tick();

        // 3*5: k=3, four edges to done; start held through the RUN cycles
        launch(32'd3, 32'd5, 5'd9);
        wait_done("basic", 4, 1'b1, 32'd15, 5'd9);
        finish_idle("basic", 32'd15, 5'd9);

        // Multiplier zero goes straight to DONE
        launch(32'h0000_1234, 32'd0, 5'd4);
        wait_done("rtzero", 1, 1'b0, 32'd0, 5'd4);
        finish_idle("rtzero", 32'd0, 5'd4);

        // Top multiplier bit: full 32 iterations
        launch(32'd1, 32'h8000_0000, 5'd31);
        wait_done("msb", 33, 1'b0, 32'h8000_0000, 5'd31);
        finish_idle("msb", 32'h8000_0000, 5'd31);

        // 2^16 * 2^16 overflows to zero
        launch(32'h0001_0000, 32'h0001_0000, 5'd7);
        wait_done("trunc", 18, 1'b0, 32'd0, 5'd7);
        finish_idle("trunc", 32'd0, 5'd7);

        // -1 * 3 = -3
        launch(32'hFFFF_FFFF, 32'd3, 5'd12);
        wait_done("signed", 3, 1'b0, 32'hFFFF_FFFD, 5'd12);
        finish_idle("signed", 32'hFFFF_FFFD, 5'd12);

        // Flush on the second RUN cycle aborts without a write
        launch(32'd2, 32'h0000_00F0, 5'd3);
        tick();
        start = 1'b0;
        #1;
        check_eq("flush_run1_stall", {31'd0, stall}, 32'd1);
        tick();
        flush = 1'b1;
        #1;
        check_eq("flush_run2_stall", {31'd0, stall}, 32'd1);
        tick();
        flush = 1'b0;
        #1;
        check_eq("flush_after_stall", {31'd0, stall}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        check_eq("flush_no_done", {31'd0, seen_done}, 32'd0);
        check_eq("flush_hold_result", result, 32'hFFFF_FFFD);
        launch(32'd4, 32'd2, 5'd6);
        wait_done("postflush", 3, 1'b0, 32'd8, 5'd6);
        finish_idle("postflush", 32'd8, 5'd6);

        // Flush beats start in IDLE
        start    = 1'b1;
        flush    = 1'b1;
        rs_val   = 32'd9;
        rt_val   = 32'd9;
        dest_reg = 5'd1;
        #1;
        check_eq("flushprio_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        flush = 1'b0;
        #1;
        check_eq("flushprio_stall2", {31'd0, stall}, 32'd0);
        tick();
        #1;
        check_eq("flushprio_done", {31'd0, done}, 32'd0);
        check_eq("flushprio_result", result, 32'd8);

        // Back-to-back: second start in the first DONE cycle keeps stall high
        launch(32'd3, 32'd5, 5'd10);
        wait_done("b2b_first", 4, 1'b0, 32'd15, 5'd10);
        start    = 1'b1;
        rs_val   = 32'd6;
        rt_val   = 32'd7;
        dest_reg = 5'd11;
        #1;
        check_eq("b2b_donecyc_stall", {31'd0, stall}, 32'd1);
        wait_done("b2b_second", 4, 1'b0, 32'd42, 5'd11);
        finish_idle("b2b_second", 32'd42, 5'd11);

        // Reset mid-RUN clears everything and no write follows
        launch(32'd7, 32'h0000_00FF, 5'd5);
        tick();
        start = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        #1;
        check_eq("midrst_stall", {31'd0, stall}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_regwrite", {31'd0, reg_write}, 32'd0);
        check_eq("midrst_result", result, 32'd0);
        check_eq("midrst_resreg", {27'd0, result_reg}, 32'd0);
        tick();
        RESET = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || stall === 1'b1) seen_done = 1'b1;
        end
        check_eq("midrst_no_done", {31'd0, seen_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
